// File: rtl/mem_reader.sv
// mem_reader: DMA readback engine. Reads a run of consecutive entries from one
// parameter-memory block and streams each entry as 13 AXIS words in the same
// format the memory writer consumes (block, address, 11 field words).
module mem_reader #(
  parameter int NB      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [$clog2(NB)-1:0] mem_sel,
  output logic [15:0]           mem_addr,
  input  logic [255:0]          mem_dout,
  input  logic                  START_REG,
  input  logic [$clog2(NB)-1:0] BLOCK_REG,
  input  logic [15:0]           ADDR_REG,
  input  logic [15:0]           LEN_REG,
  output logic                  BUSY_REG
);

  localparam int BW = $clog2(NB);
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SEND,
    END
  } state_t;

  state_t          state_r, state_n;
  logic [1:0]      sync_r;
  logic            start_s;
  logic [BW-1:0]   blk_r, blk_n;
  logic [15:0]     addr_r, addr_n;
  logic [15:0]     rem_r, rem_n;
  logic [LW-1:0]   lat_r, lat_n;
  logic [3:0]      wcnt_r, wcnt_n;
  logic [183:0]    entry_r, entry_n;
  logic            tvalid_n, tlast_n, busy_n;
  logic [31:0]     tdata_n;
  logic [BW-1:0]   mem_sel_n;
  logic [15:0]     mem_addr_n;

  // Entry bits above CTRL are reserved and never streamed out.
  logic unused_hi;
  assign unused_hi = ^mem_dout[255:184];

  assign start_s = sync_r[1];

  // Word map of one entry: block, address, then the packed fields.
  function automatic logic [31:0] word_at(input logic [3:0]    idx,
                                          input logic [183:0]  e,
                                          input logic [BW-1:0] b,
                                          input logic [15:0]   a);
    logic [31:0] w;
    case (idx)
      4'd0:    w = 32'(b);
      4'd1:    w = 32'(a);
      4'd2:    w = 32'(e[17:0]);
      4'd3:    w = 32'(e[35:18]);
      4'd4:    w = 32'(e[53:36]);
      4'd5:    w = 32'(e[71:54]);
      4'd6:    w = 32'(e[89:72]);
      4'd7:    w = 32'(e[107:90]);
      4'd8:    w = 32'(e[125:108]);
      4'd9:    w = 32'(e[141:126]);
      4'd10:   w = 32'(e[157:142]);
      4'd11:   w = 32'(e[175:158]);
      4'd12:   w = 32'(e[183:176]);
      default: w = '0;
    endcase
    return w;
  endfunction

  // Two-flop resynchroniser for the asynchronous start level.
  always_ff @(posedge clk) begin
    if (!rstn) sync_r <= '0;
    else       sync_r <= {sync_r[0], START_REG};
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r       <= IDLE;
      blk_r         <= '0;
      addr_r        <= '0;
      rem_r         <= '0;
      lat_r         <= '0;
      wcnt_r        <= '0;
      entry_r       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      mem_sel       <= '0;
      mem_addr      <= '0;
      BUSY_REG      <= 1'b0;
    end else begin
      state_r       <= state_n;
      blk_r         <= blk_n;
      addr_r        <= addr_n;
      rem_r         <= rem_n;
      lat_r         <= lat_n;
      wcnt_r        <= wcnt_n;
      entry_r       <= entry_n;
      m_axis_tvalid <= tvalid_n;
      m_axis_tdata  <= tdata_n;
      m_axis_tlast  <= tlast_n;
      mem_sel       <= mem_sel_n;
      mem_addr      <= mem_addr_n;
      BUSY_REG      <= busy_n;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every port comes straight from a flop.
  always_comb begin
    state_n    = state_r;
    blk_n      = blk_r;
    addr_n     = addr_r;
    rem_n      = rem_r;
    lat_n      = lat_r;
    wcnt_n     = wcnt_r;
    entry_n    = entry_r;
    tvalid_n   = m_axis_tvalid;
    tdata_n    = m_axis_tdata;
    tlast_n    = m_axis_tlast;
    mem_sel_n  = mem_sel;
    mem_addr_n = mem_addr;
    busy_n     = BUSY_REG;

    case (state_r)
      IDLE: begin
        if (start_s) begin
          blk_n  = BLOCK_REG;
          addr_n = ADDR_REG;
          rem_n  = LEN_REG;
          busy_n = 1'b1;
          if (LEN_REG == 16'd0) begin
            state_n = END;
          end else begin
            state_n    = FETCH;
            mem_sel_n  = BLOCK_REG;
            mem_addr_n = ADDR_REG;
            lat_n      = '0;
          end
        end
      end

      FETCH: begin
        if (lat_r == LW'(MEM_LAT - 1)) state_n = CAPTURE;
        else                           lat_n   = lat_r + 1'b1;
      end

      CAPTURE: begin
        entry_n  = mem_dout[183:0];
        wcnt_n   = '0;
        tvalid_n = 1'b1;
        tdata_n  = word_at(4'd0, entry_r, blk_r, addr_r);
        tlast_n  = 1'b0;
        state_n  = SEND;
      end

      SEND: begin
        if (m_axis_tvalid && m_axis_tready) begin
          if (wcnt_r != 4'd12) begin
            // The following word reads the entry register, which is
            // already loaded here since CAPTURE preceded this state.
            wcnt_n  = wcnt_r + 4'd1;
            tdata_n = word_at(wcnt_r + 4'd1, entry_r, blk_r, addr_r);
            tlast_n = (wcnt_r == 4'd11) && (rem_r == 16'd1);
          end else begin
            tvalid_n = 1'b0;
            tlast_n  = 1'b0;
            if (rem_r > 16'd1) begin
              rem_n      = rem_r - 16'd1;
              addr_n     = addr_r + 16'd1;
              mem_sel_n  = blk_r;
              mem_addr_n = addr_r + 16'd1;
              lat_n      = '0;
              state_n    = FETCH;
            end else begin
              busy_n  = 1'b0;
              state_n = END;
            end
          end
        end
      end

      END: begin
        tvalid_n = 1'b0;
        busy_n   = 1'b0;
        if (!start_s) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_reader.sv
// tb_mem_reader: randomized scoreboard bench for mem_reader. A memory model
// with MEM_LAT pipeline stages feeds the DUT; expected words are derived from
// the memory contents and the field layout and queued before each start.
module tb_mem_reader;

  localparam int NB      = 32;
  localparam int MEM_LAT = 2;

  logic         clk = 1'b0;
  logic         rstn;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tlast;
  logic [4:0]   mem_sel;
  logic [15:0]  mem_addr;
  logic [255:0] mem_dout;
  logic         START_REG;
  logic [4:0]   BLOCK_REG;
  logic [15:0]  ADDR_REG;
  logic [15:0]  LEN_REG;
  logic         BUSY_REG;

  mem_reader #(.NB(NB), .MEM_LAT(MEM_LAT)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .mem_sel      (mem_sel),
    .mem_addr     (mem_addr),
    .mem_dout     (mem_dout),
    .START_REG    (START_REG),
    .BLOCK_REG    (BLOCK_REG),
    .ADDR_REG     (ADDR_REG),
    .LEN_REG      (LEN_REG),
    .BUSY_REG     (BUSY_REG)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  int           tests = 0;
  int           fails = 0;
  int           hs_count = 0;
  int           last_count = 0;
  int           tr_mode = 0;  // 0: always ready, 1: random, 2: driven by test
  logic [31:0]  got_q[$];
  exp_t         exp_q[$];
  logic [255:0] mem[int];
  logic [255:0] d1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] mem_read(input logic [4:0] b, input logic [15:0] a);
    int key;
    key = int'({b, a});
    if (mem.exists(key)) return mem[key];
    return '0;
  endfunction

  // Memory with MEM_LAT register stages from address to data.
  always @(posedge clk) begin
    d1       <= mem_read(mem_sel, mem_addr);
    mem_dout <= d1;
  end

  task automatic fill(input logic [4:0] b, input logic [15:0] a, input int len);
    for (int i = 0; i < len; i++) begin
      logic [15:0] ea;
      ea = a + 16'(i);
      mem[int'({b, ea})] = {$urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Reference model: block word, address word, then fields by width.
  task automatic expect_transfer(input logic [4:0] b, input logic [15:0] a, input int len);
    int widths[11] = '{18, 18, 18, 18, 18, 18, 18, 16, 16, 18, 8};
    for (int i = 0; i < len; i++) begin
      logic [15:0]  ea;
      logic [255:0] e;
      int           lo;
      exp_t         x;
      ea = a + 16'(i);
      e  = mem_read(b, ea);
      lo = 0;
      x.d = 32'(b);  x.l = 1'b0; exp_q.push_back(x);
      x.d = 32'(ea); x.l = 1'b0; exp_q.push_back(x);
      for (int f = 0; f < 11; f++) begin
        x.d = 32'((e >> lo) & ((256'd1 << widths[f]) - 256'd1));
        x.l = (i == len - 1) && (f == 10);
        exp_q.push_back(x);
        lo += widths[f];
      end
    end
  endtask

  task automatic start_xfer(input logic [4:0] b, input logic [15:0] a, input logic [15:0] len,
                            input bit hold);
    bit seen;
    BLOCK_REG = b;
    ADDR_REG  = a;
    LEN_REG   = len;
    @(posedge clk); #1;
    START_REG = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (BUSY_REG) seen = 1'b1;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL busy_rise: got timeout expected BUSY_REG=1");
    end
    if (!hold) begin
      @(posedge clk); #1;
      START_REG = 1'b0;
    end
  endtask

  task automatic wait_done(input string name, input int bound);
    bit done;
    done = 1'b0;
    for (int n = 0; n < bound && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !BUSY_REG) done = 1'b1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s: got timeout with %0d words pending expected completion", name, exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({tag, "_tdata"},  m_axis_tdata,       32'd0);
    check({tag, "_tlast"},  32'(m_axis_tlast),  32'd0);
    check({tag, "_sel"},    32'(mem_sel),       32'd0);
    check({tag, "_addr"},   32'(mem_addr),      32'd0);
    check({tag, "_busy"},   32'(BUSY_REG),      32'd0);
  endtask

  // tready driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tr_mode == 0)      m_axis_tready = 1'b1;
      else if (tr_mode == 1) m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks AXIS stability.
  initial begin
    bit          stall;
    logic [31:0] pd;
    logic        pl;
    exp_t        e;
    stall = 1'b0;
    pd    = '0;
    pl    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", 32'(m_axis_tvalid), 32'd1);
          check("hold_data",  m_axis_tdata,       pd);
          check("hold_last",  32'(m_axis_tlast),  32'(pl));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          hs_count++;
          got_q.push_back(m_axis_tdata);
          if (m_axis_tlast) last_count++;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_word: got 0x%0h expected no word", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            check("word_data", m_axis_tdata,      e.d);
            check("word_last", 32'(m_axis_tlast), 32'(e.l));
          end
        end
        stall = m_axis_tvalid && !m_axis_tready;
        pd    = m_axis_tdata;
        pl    = m_axis_tlast;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          hb, gb, lb, cnt, cnt2;
    logic [4:0]  b;
    logic [15:0] a;
    bit          hit;

    rstn          = 1'b0;
    m_axis_tready = 1'b1;
    START_REG     = 1'b0;
    BLOCK_REG     = '0;
    ADDR_REG      = '0;
    LEN_REG       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Known entry, single-entry transfer.
    mem[int'({5'd3, 16'h0010})] = {72'hDEADBEEF0123456789, 8'hA5, 18'h29999, 16'h8888,
                                   16'h7777, 18'h36666, 18'h05555, 18'h14444, 18'h03333,
                                   18'h22222, 18'h21111, 18'h12345};
    hb = hs_count; gb = got_q.size(); lb = last_count;
    expect_transfer(5'd3, 16'h0010, 1);
    start_xfer(5'd3, 16'h0010, 16'd1, 1'b0);
    wait_done("t1_done", 300);
    check("t1_count", 32'(hs_count - hb), 32'd13);
    check("t1_w0",  got_q[gb + 0],  32'h3);
    check("t1_w1",  got_q[gb + 1],  32'h10);
    check("t1_w2",  got_q[gb + 2],  32'h12345);
    check("t1_w3",  got_q[gb + 3],  32'h21111);
    check("t1_w8",  got_q[gb + 8],  32'h36666);
    check("t1_w11", got_q[gb + 11], 32'h29999);
    check("t1_w12", got_q[gb + 12], 32'hA5);
    check("t1_lasts", 32'(last_count - lb), 32'd1);
    check("t1_busy", 32'(BUSY_REG), 32'd0);
    repeat (4) @(posedge clk);

    // Address wrap across 0xFFFF.
    fill(5'd0, 16'hFFFE, 3);
    hb = hs_count; gb = got_q.size(); lb = last_count;
    expect_transfer(5'd0, 16'hFFFE, 3);
    start_xfer(5'd0, 16'hFFFE, 16'd3, 1'b0);
    wait_done("t2_done", 500);
    check("t2_count", 32'(hs_count - hb), 32'd39);
    check("t2_a0", got_q[gb + 1],  32'hFFFE);
    check("t2_a1", got_q[gb + 14], 32'hFFFF);
    check("t2_a2", got_q[gb + 27], 32'h0000);
    check("t2_lasts", 32'(last_count - lb), 32'd1);
    repeat (4) @(posedge clk);

    // Random backpressure.
    tr_mode = 1;
    b = 5'($urandom_range(0, NB - 1));
    a = 16'($urandom);
    fill(b, a, 4);
    hb = hs_count; lb = last_count;
    expect_transfer(b, a, 4);
    start_xfer(b, a, 16'd4, 1'b0);
    wait_done("t3_done", 2000);
    check("t3_count", 32'(hs_count - hb), 32'd52);
    check("t3_lasts", 32'(last_count - lb), 32'd1);
    tr_mode = 0;
    repeat (4) @(posedge clk);

    // Zero length with START held high: busy pulse, no words, no retrigger.
    hb = hs_count;
    start_xfer(5'd7, 16'h1234, 16'd0, 1'b1);
    cnt = 0; cnt2 = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_axis_tvalid) cnt++;
      if (BUSY_REG) cnt2++;
    end
    check("t4_no_valid", 32'(cnt), 32'd0);
    check("t4_no_retrigger", 32'(cnt2), 32'd0);
    check("t4_count", 32'(hs_count - hb), 32'd0);
    @(posedge clk); #1;
    START_REG = 1'b0;
    repeat (6) @(posedge clk);
    b = 5'($urandom_range(0, NB - 1));
    a = 16'($urandom);
    fill(b, a, 1);
    hb = hs_count;
    expect_transfer(b, a, 1);
    start_xfer(b, a, 16'd1, 1'b0);
    wait_done("t4b_done", 300);
    check("t4b_count", 32'(hs_count - hb), 32'd13);
    repeat (4) @(posedge clk);

    // Register changes and START drop mid-transfer are ignored.
    b = 5'($urandom_range(0, NB - 1));
    a = 16'($urandom);
    fill(b, a, 2);
    hb = hs_count;
    expect_transfer(b, a, 2);
    start_xfer(b, a, 16'd2, 1'b1);
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge clk);
      if (hs_count - hb >= 5) hit = 1'b1;
    end
    check("t5_progress", 32'(hit), 32'd1);
    @(posedge clk); #1;
    START_REG = 1'b0;
    ADDR_REG  = a ^ 16'h5555;
    BLOCK_REG = b ^ 5'd1;
    LEN_REG   = 16'd7;
    wait_done("t5_done", 500);
    check("t5_count", 32'(hs_count - hb), 32'd26);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (BUSY_REG) cnt++;
    end
    check("t5_no_restart", 32'(cnt), 32'd0);

    // Reset while word 7 is stalled.
    b = 5'($urandom_range(1, NB - 1));
    a = 16'($urandom_range(1, 16'hFFFF));
    fill(b, a, 3);
    hb = hs_count; lb = last_count;
    expect_transfer(b, a, 3);
    tr_mode = 2;
    m_axis_tready = 1'b1;
    start_xfer(b, a, 16'd3, 1'b0);
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(posedge clk); #1;
      if (hs_count - hb == 6) begin
        m_axis_tready = 1'b0;
        hit = 1'b1;
      end
    end
    check("t6_reach_w7", 32'(hit), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("t6_stalled_valid", 32'(m_axis_tvalid), 32'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check_reset_outputs("t6_rst");
    check("t6_lasts", 32'(last_count - lb), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn    = 1'b1;
    tr_mode = 0;
    repeat (3) @(posedge clk);
    b = 5'($urandom_range(0, NB - 1));
    a = 16'($urandom);
    fill(b, a, 1);
    hb = hs_count; lb = last_count;
    expect_transfer(b, a, 1);
    start_xfer(b, a, 16'd1, 1'b0);
    wait_done("t6b_done", 300);
    check("t6b_count", 32'(hs_count - hb), 32'd13);
    check("t6b_lasts", 32'(last_count - lb), 32'd1);
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
